// File: rtl/deserializador_pkg.sv
// Shared types, default sizes and width helpers for the serial-to-word deserialiser.
package deserializador_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef enum logic [0:0] {
    RECEIVE,
    WAIT
  } state_t;

  // Width of a counter that must hold every value from 0 to n inclusive.
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Width of an index into n entries, never narrower than one bit.
  function automatic int unsigned index_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/deserializador_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head, count and ready.
module sync_fifo
  import deserializador_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            push,
  input  logic [WIDTH-1:0]                push_data,
  input  logic                            pop,
  output logic                            full,
  output logic                            empty,
  output logic [count_width(DEPTH)-1:0]   count,
  output logic [WIDTH-1:0]                head
);

  localparam int unsigned PW = index_width(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             ready_q, ready_d;
  logic             push_eff, pop_eff;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = ~ready_q;
  assign count    = count_q;
  assign head     = head_q;
  assign pop_eff  = pop & ready_q;
  // A pop in the same cycle frees the slot a push at full needs.
  assign push_eff = push & (~full | pop_eff);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_eff) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
    unique case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != '0);
    // Head is precomputed so data_out is a flop, including the write-through case.
    if (!ready_d) begin
      head_d = '0;
    end else if (push_eff && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_data;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clock) begin
    if (push_eff) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      ready_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: rtl/deserializador_fifo.sv
// Serial-to-word deserialiser: shifter, bit counter, hold register and FSM feeding an
// output FIFO; a full FIFO parks the finished word and stalls the serial producer.
module deserializador_fifo
  import deserializador_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          data_in,
  input  logic                          write_in,
  input  logic                          ack_in,
  output logic                          status_out,
  output logic [WIDTH-1:0]              data_out,
  output logic                          data_ready,
  output logic [count_width(DEPTH)-1:0] count_out,
  output logic                          overflow_out
);

  localparam int unsigned BCW = index_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, shift_next;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             overflow_q, overflow_d;
  logic             push;
  logic [WIDTH-1:0] push_word;
  logic             fifo_full, fifo_empty;
  logic             pop_eff, accept, last_bit;

  assign status_out   = (state_q == RECEIVE);
  assign accept       = write_in & status_out;
  assign pop_eff      = ack_in & ~fifo_empty;
  assign last_bit     = (bit_cnt_q == BCW'(WIDTH - 1));
  assign data_ready   = ~fifo_empty;
  assign overflow_out = overflow_q;

  always_comb begin
    if (MSB_FIRST) begin
      shift_next = {shift_q[WIDTH-2:0], data_in};
    end else begin
      shift_next = {data_in, shift_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    hold_d     = hold_q;
    push       = 1'b0;
    push_word  = shift_next;
    overflow_d = overflow_q | (write_in & ~status_out);
    unique case (state_q)
      RECEIVE: begin
        if (accept) begin
          shift_d = shift_next;
          if (last_bit) begin
            bit_cnt_d = '0;
            if (!fifo_full || pop_eff) begin
              push = 1'b1;
            end else begin
              hold_d  = shift_next;
              state_d = WAIT;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      WAIT: begin
        // FIFO is full here, so any ack frees exactly the slot the held word needs.
        push_word = hold_q;
        if (pop_eff) begin
          push    = 1'b1;
          state_d = RECEIVE;
        end
      end
      default: state_d = RECEIVE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RECEIVE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      hold_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_q     <= hold_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .pop       (ack_in),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count_out),
    .head      (data_out)
  );

endmodule

// File: tb/tb_deserializador_fifo.sv
// Bench for deserializador_fifo: MSB-first and LSB-first instances share stimulus and are
// checked against a queue-based reference model, constant vectors and corner sequences.
module tb_deserializador_fifo;

  localparam int W = 8;
  localparam int D = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         data_in = 1'b0;
  logic         write_in = 1'b0;
  logic         ack_in = 1'b0;
  logic         status_m, status_l, rdy_m, rdy_l, ovf_m, ovf_l;
  logic [W-1:0] dout_m, dout_l;
  logic [1:0]   cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] qm[$];
  logic [W-1:0] ql[$];
  bit           bits[$];
  bit           hold_v;
  logic [W-1:0] hm, hl;
  bit           ovf;

  typedef struct {
    logic [7:0] serial;  // transmitted left to right, bit 7 first
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  vec_t vecs[4];

  always #5 clock = ~clock;

  deserializador_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) dut_m (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .write_in     (write_in),
    .ack_in       (ack_in),
    .status_out   (status_m),
    .data_out     (dout_m),
    .data_ready   (rdy_m),
    .count_out    (cnt_m),
    .overflow_out (ovf_m)
  );

  deserializador_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) dut_l (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .write_in     (write_in),
    .ack_in       (ack_in),
    .status_out   (status_l),
    .data_out     (dout_l),
    .data_ready   (rdy_l),
    .count_out    (cnt_l),
    .overflow_out (ovf_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] assemble(input bit msb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) w[W-1-i] = bits[i];
      else     w[i] = bits[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    qm.delete();
    ql.delete();
    bits.delete();
    hold_v = 0;
    ovf    = 0;
  endtask

  task automatic model_step(input bit d, input bit wr, input bit ack);
    bit           accepting;
    bit           pop;
    logic [W-1:0] wm, wl;
    accepting = !hold_v;
    pop       = ack && (qm.size() > 0);
    if (wr && !accepting) ovf = 1;
    if (pop) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
    if (accepting && wr) begin
      bits.push_back(d);
      if (bits.size() == W) begin
        wm = assemble(1);
        wl = assemble(0);
        bits.delete();
        if (qm.size() < D) begin
          qm.push_back(wm);
          ql.push_back(wl);
        end else begin
          hm     = wm;
          hl     = wl;
          hold_v = 1;
        end
      end
    end else if (hold_v && pop) begin
      qm.push_back(hm);
      ql.push_back(hl);
      hold_v = 0;
    end
  endtask

  task automatic compare_all();
    logic [W-1:0] em, el;
    em = (qm.size() > 0) ? qm[0] : '0;
    el = (ql.size() > 0) ? ql[0] : '0;
    chk("data_out_msb", dout_m, em);
    chk("data_out_lsb", dout_l, el);
    chk("ready_msb", rdy_m, qm.size() > 0);
    chk("ready_lsb", rdy_l, ql.size() > 0);
    chk("count_msb", cnt_m, qm.size());
    chk("count_lsb", cnt_l, ql.size());
    chk("status_msb", status_m, !hold_v);
    chk("status_lsb", status_l, !hold_v);
    chk("overflow_msb", ovf_m, ovf);
    chk("overflow_lsb", ovf_l, ovf);
  endtask

  task automatic cycle(input bit d, input bit wr, input bit ack);
    data_in  = d;
    write_in = wr;
    ack_in   = ack;
    @(posedge clock);
    model_step(d, wr, ack);
    #1;
    data_in  = 1'b0;
    write_in = 1'b0;
    ack_in   = 1'b0;
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ack_last);
    for (int i = 7; i >= 0; i--) cycle(b[i], 1'b1, (i == 0) ? ack_last : 1'b0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("reset_data", dout_m, 0);
    chk("reset_ready", rdy_m, 0);
    chk("reset_count", cnt_m, 0);
    chk("reset_status", status_m, 1);
    chk("reset_overflow", ovf_m, 0);
    compare_all();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    vecs[0] = '{serial: 8'b1010_0101, exp_m: 8'hA5, exp_l: 8'hA5};
    vecs[1] = '{serial: 8'b1100_0000, exp_m: 8'hC0, exp_l: 8'h03};
    vecs[2] = '{serial: 8'b0000_0001, exp_m: 8'h01, exp_l: 8'h80};
    vecs[3] = '{serial: 8'b1111_0000, exp_m: 8'hF0, exp_l: 8'h0F};

    model_reset();
    do_reset();

    // Single-word assembly in both bit orders
    foreach (vecs[i]) begin
      do_reset();
      send_byte(vecs[i].serial, 1'b0);
      chk("vec_data_msb", dout_m, vecs[i].exp_m);
      chk("vec_data_lsb", dout_l, vecs[i].exp_l);
      chk("vec_ready", rdy_m, 1);
      chk("vec_count", cnt_m, 1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("vec_drained", cnt_m, 0);
    end

    // Backpressure into WAIT, overflow, simultaneous pop+push at full
    do_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    chk("bp_count", cnt_m, 2);
    chk("bp_status", status_m, 0);
    chk("bp_head", dout_m, 8'h11);
    cycle(1'b1, 1'b1, 1'b0);
    chk("bp_overflow", ovf_m, 1);
    chk("bp_still_wait", status_m, 0);
    cycle(1'b0, 1'b0, 1'b1);
    chk("bp_release_count", cnt_m, 2);
    chk("bp_release_status", status_m, 1);
    chk("bp_head_22", dout_m, 8'h22);
    chk("bp_head_22_lsb", dout_l, 8'h44);
    cycle(1'b0, 1'b0, 1'b1);
    chk("bp_head_33", dout_m, 8'h33);
    chk("bp_head_33_lsb", dout_l, 8'hCC);
    cycle(1'b0, 1'b0, 1'b1);
    chk("bp_empty_data", dout_m, 0);
    chk("bp_empty_ready", rdy_m, 0);
    chk("bp_overflow_sticky", ovf_m, 1);

    // Ack on empty FIFO, then ack on a word's last-bit cycle
    do_reset();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("empty_ack_count", cnt_m, 0);
    chk("empty_ack_data", dout_m, 0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hC3, 1'b1);
    chk("ack_last_count", cnt_m, 1);
    chk("ack_last_head", dout_m, 8'hC3);

    // Reset mid-word with a queued word, then a clean word
    do_reset();
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
    do_reset();
    send_byte(8'h36, 1'b0);
    chk("post_reset_msb", dout_m, 8'h36);
    chk("post_reset_lsb", dout_l, 8'h6C);
    chk("post_reset_count", cnt_m, 1);

    // Randomised traffic against the model, with one reset midway
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/deserializador_fifo.md
Name: deserializador_fifo

Overview:
- Parametrised successor to the 8-bit deserialiser: shifts in a 1-bit serial stream, assembles WIDTH-bit words and queues them in a DEPTH-entry output FIFO.
- Consumer pops words with an ack handshake; a held-word WAIT state applies backpressure to the serial producer instead of overwriting data.
- Sits between the serial link front-end and the word-level consumer (queue/processing stage).

Parameters:
- WIDTH, 8, bits per assembled word (>=2).
- DEPTH, 4, output FIFO entries (power of two, >=2).
- MSB_FIRST, 1, 1: first received bit lands in data_out[WIDTH-1]; 0: first bit lands in data_out[0].

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  in  1  serial bit, sampled when write_in=1.
- write_in  in  1  serial bit valid; bit is accepted only if status_out=1 in the same cycle.
- ack_in  in  1  consumer pop; effective only when data_ready=1.
- status_out  out  1  1 = block can accept a serial bit this cycle.
- data_out  out  WIDTH  FIFO head word (first-word-fall-through); 0 when empty.
- data_ready  out  1  FIFO non-empty.
- count_out  out  $clog2(DEPTH+1)  words currently queued.
- overflow_out  out  1  sticky: write_in seen while status_out=0.

Behaviour:
- Reset (reset=0, async): state=RECEIVE, shift register=0, bit counter=0, FIFO empty, data_out=0, data_ready=0, count_out=0, status_out=1, overflow_out=0. Reset mid-word or mid-WAIT discards all partial and queued data.
- FSM states: RECEIVE, WAIT.
- RECEIVE: status_out=1. On write_in, shift data_in in (per MSB_FIRST) and increment bit counter.
  - On the WIDTH-th bit: if FIFO not full, or full with an effective ack_in the same cycle, push the completed word. Counter returns to 0; stay in RECEIVE.
  - Otherwise latch the word in the hold register and go to WAIT.
- WAIT: status_out=0. No bits are accepted. When ack_in is effective, push the held word in that same cycle (simultaneous push+pop at full, so count stays DEPTH) and return to RECEIVE.
- Latency: the word is visible on data_out with data_ready=1 one cycle after the clock edge that samples its last bit, if the FIFO was empty.
- Pop: an effective ack_in removes the head at the clock edge; the next head, or 0, appears the following cycle. ack_in with data_ready=0 is ignored without error.
- Simultaneous push and pop with the FIFO non-full and non-empty: count is unchanged and ordering is preserved.
- Pointers wrap modulo DEPTH. count_out is exact from 0 to DEPTH.
- write_in while status_out=0: the bit is dropped and overflow_out is set and held until reset.
- All outputs are registered except status_out, which is decoded from state.

Decomposition:
- Package deserializador_pkg holds:
  - state_t enum {RECEIVE, WAIT};
  - function clog2-based width helpers;
  - the default WIDTH/DEPTH localparams.
- Sub-module sync_fifo (WIDTH, DEPTH): push/pop/full/empty/count with first-word-fall-through head. The top level holds the shifter, bit counter, hold register and FSM.

Test Plan (WIDTH=8, DEPTH=2 unless noted):
- Reset then serial bits 1,0,1,0,0,1,0,1 with MSB_FIRST=1 -> one cycle after the 8th bit: data_out=8'hA5, data_ready=1, count_out=1.
- Same bits with MSB_FIRST=0 -> data_out=8'hA5 bit-reversed = 8'hA5; repeat with 1,1,0,0,0,0,0,0 -> 8'h03 (MSB_FIRST=0) versus 8'hC0 (MSB_FIRST=1).
- Send 8'h11, 8'h22, 8'h33 with no ack -> count_out=2 and state WAIT after the 24th bit, status_out=0. Pulse ack_in -> 8'h11 popped, 8'h33 pushed in the same edge, count_out=2, status_out=1. Next pops return 8'h22 then 8'h33.
- Assert write_in during WAIT -> bit ignored, overflow_out=1 and still 1 after the consumer drains the FIFO.
- ack_in pulses with the FIFO empty -> no change, count_out=0. Ack the last-bit cycle of a word while count_out=1 -> count_out stays 1, order preserved.
- Drop reset to 0 after 5 bits of a word with 1 word queued -> immediately data_ready=0, count_out=0, data_out=0. After release, a fresh 8 bits produce the correct word with no stale bits.
